// File: rtl/hdmi_link_manager_if.sv
// I2C request/completion bus between the link manager (master side) and an external I2C engine.
interface hdmi_link_manager_if;
    logic       ready;
    logic [6:0] address;
    logic       rw;
    logic [7:0] register;
    logic [7:0] data_write;
    logic       valid;
    logic       nack;
    logic [7:0] data_read;

    modport master (
        output ready, address, rw, register, data_write,
        input  valid, nack, data_read
    );
    modport slave (
        input  ready, address, rw, register, data_write,
        output valid, nack, data_read
    );
endinterface

// File: rtl/hdmi_link_manager.sv
// HPD-driven HDMI link bring-up: debounce, redriver table, SCDC probe, TMDS config, bounded retries.
// Optional HDMI_LINK_SCDC_POLL_EN: periodic SCDC TMDS-config readback while running.
module hdmi_link_manager #(
    parameter int             CLOCK_FREQUENCY  = 0,
    parameter int             DEBOUNCE_MS      = 100,
    parameter int             BACKOFF_MS       = 100,
    parameter int             RETRY_LIMIT      = 3,
    parameter logic [6:0]     REDRIVER_ADDRESS = 7'h5E,
    parameter int             REDRIVER_COUNT   = 9,
    parameter logic [255:0]   REDRIVER_TABLE   = '0,
    parameter int             POLL_MS          = 1000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       hpd,
    input  logic                       over_340mhz,
    hdmi_link_manager_if.master        i2c,
    output logic                       link_run,
    output logic                       scrambler_enable,
    output logic                       tmds_bit_clock_ratio,
    output logic                       hdmi2_sink,
    output logic                       link_error
);

    localparam int              TICK_DIV = (CLOCK_FREQUENCY >= 1000) ? CLOCK_FREQUENCY / 1000 : 1;
    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]      SCDC_ADDR     = 7'h54;
    localparam logic [7:0]      SCDC_VERSION  = 8'h02;
    localparam logic [7:0]      SCDC_TMDS_CFG = 8'h20;
    localparam logic [4:0]      LAST_IDX      = 5'(REDRIVER_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEBOUNCE, S_CFG_REDRIVER, S_PROBE_SCDC, S_CFG_TMDS, S_RUN, S_BACKOFF, S_FAIL
    } state_e;

    typedef struct packed {
        logic [6:0] address;
        logic       rw;
        logic [7:0] register;
        logic [7:0] data;
    } i2c_req_t;

    function automatic i2c_req_t wr_req(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        i2c_req_t q;
        q.address  = a;
        q.rw       = 1'b0;
        q.register = r;
        q.data     = d;
        return q;
    endfunction

    function automatic i2c_req_t table_req(input logic [3:0] i);
        logic [15:0] e;
        e = REDRIVER_TABLE[{i, 4'h0} +: 16];
        return wr_req(REDRIVER_ADDRESS, e[15:8], e[7:0]);
    endfunction

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [15:0]      ms_q, ms_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       retry_q, retry_d;
    i2c_req_t         req_q, req_d;
    logic             ready_q, ready_d;
    logic             link_q, link_d;
    logic             scr_q, scr_d;
    logic             ratio_q, ratio_d;
    logic             hdmi2_q, hdmi2_d;
    logic             err_q, err_d;
    logic             poll_q, poll_d;

    logic     tick, done, start_cfg, retry_now, enter_run;
    i2c_req_t tmds_req;

    assign tmds_req = wr_req(SCDC_ADDR, SCDC_TMDS_CFG, {6'b0, over_340mhz, over_340mhz});

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ms_d      = ms_q;
        retry_d   = retry_q;
        req_d     = req_q;
        ready_d   = ready_q;
        link_d    = link_q;
        scr_d     = scr_q;
        ratio_d   = ratio_q;
        hdmi2_d   = hdmi2_q;
        err_d     = err_q;
        poll_d    = poll_q;
        start_cfg = 1'b0;
        retry_now = 1'b0;
        enter_run = 1'b0;

        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick && ms_q != 16'd0) ms_d = ms_q - 16'd1;
        // a completion only counts while a request is actually outstanding
        done  = ready_q && i2c.valid;

        case (state_q)
            S_IDLE: begin
                if (hpd) begin
                    state_d = S_DEBOUNCE;
                    ms_d    = 16'(DEBOUNCE_MS - 1);
                    pre_d   = '0;
                end
            end
            S_DEBOUNCE, S_BACKOFF: begin
                if (tick && ms_q == 16'd0) start_cfg = 1'b1;
            end
            S_CFG_REDRIVER: begin
                if (done) begin
                    if (i2c.nack) begin
                        retry_now = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_PROBE_SCDC;
                        req_d   = wr_req(SCDC_ADDR, SCDC_VERSION, 8'h01);
                    end else begin
                        idx_d = idx_q + 5'd1;
                        req_d = table_req(idx_q[3:0] + 4'd1);
                    end
                end
            end
            S_PROBE_SCDC: begin
                if (done) begin
                    if (!i2c.nack) begin
                        hdmi2_d = 1'b1;
                        state_d = S_CFG_TMDS;
                        req_d   = tmds_req;
                    end else if (!over_340mhz) begin
                        enter_run = 1'b1;
                    end else begin
                        retry_now = 1'b1;
                    end
                end
            end
            S_CFG_TMDS: begin
                if (done) begin
                    if (i2c.nack) begin
                        retry_now = 1'b1;
                    end else begin
                        scr_d     = over_340mhz;
                        ratio_d   = over_340mhz;
                        enter_run = 1'b1;
                    end
                end
            end
            S_RUN: begin
`ifdef HDMI_LINK_SCDC_POLL_EN
                if (hdmi2_q) begin
                    if (!poll_q && tick && ms_q == 16'd0) begin
                        req_d          = wr_req(SCDC_ADDR, SCDC_TMDS_CFG, 8'h00);
                        req_d.rw       = 1'b1;
                        ready_d        = 1'b1;
                        poll_d         = 1'b1;
                    end else if (poll_q && done) begin
                        poll_d = 1'b0;
                        // a sink that lost its TMDS config gets it rewritten without burning a retry
                        if (i2c.nack || i2c.data_read[1:0] != {ratio_q, scr_q}) begin
                            link_d  = 1'b0;
                            state_d = S_CFG_TMDS;
                            req_d   = tmds_req;
                        end else begin
                            ready_d = 1'b0;
                            ms_d    = 16'(POLL_MS - 1);
                            pre_d   = '0;
                        end
                    end
                end
`endif
            end
            default: ;
        endcase

        if (start_cfg) begin
            idx_d   = 5'd0;
            ready_d = 1'b1;
            if (REDRIVER_COUNT > 0) begin
                state_d = S_CFG_REDRIVER;
                req_d   = table_req(4'd0);
            end else begin
                state_d = S_PROBE_SCDC;
                req_d   = wr_req(SCDC_ADDR, SCDC_VERSION, 8'h01);
            end
        end

        if (retry_now) begin
            ready_d = 1'b0;
            if (retry_q == 4'(RETRY_LIMIT)) begin
                state_d = S_FAIL;
                err_d   = 1'b1;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = S_BACKOFF;
                ms_d    = 16'(BACKOFF_MS - 1);
                pre_d   = '0;
            end
        end

        if (enter_run) begin
            state_d = S_RUN;
            ready_d = 1'b0;
            link_d  = 1'b1;
            ms_d    = 16'(POLL_MS - 1);
            pre_d   = '0;
        end

        if (!hpd) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            link_d  = 1'b0;
            scr_d   = 1'b0;
            ratio_d = 1'b0;
            hdmi2_d = 1'b0;
            err_d   = 1'b0;
            retry_d = 4'd0;
            poll_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ms_q    <= '0;
            pre_q   <= '0;
            retry_q <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            link_q  <= 1'b0;
            scr_q   <= 1'b0;
            ratio_q <= 1'b0;
            hdmi2_q <= 1'b0;
            err_q   <= 1'b0;
            poll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ms_q    <= ms_d;
            pre_q   <= pre_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            link_q  <= link_d;
            scr_q   <= scr_d;
            ratio_q <= ratio_d;
            hdmi2_q <= hdmi2_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
        end
    end

`ifndef HDMI_LINK_SCDC_POLL_EN
    logic unused_data_read;
    assign unused_data_read = ^i2c.data_read;
`endif

    assign i2c.ready            = ready_q;
    assign i2c.address          = req_q.address;
    assign i2c.rw               = req_q.rw;
    assign i2c.register         = req_q.register;
    assign i2c.data_write       = req_q.data;
    assign link_run             = link_q;
    assign scrambler_enable     = scr_q;
    assign tmds_bit_clock_ratio = ratio_q;
    assign hdmi2_sink           = hdmi2_q;
    assign link_error           = err_q;

endmodule

// File: tb/tb_hdmi_link_manager.sv
// Bench for hdmi_link_manager: transaction-plan reference model, random I2C responder, directed scenarios.
module tb_hdmi_link_manager;
    localparam int           CF = 10000, DIV = CF / 1000, DEB = 2, BO = 1, RC = 2, RL = 1, PM = 2;
    localparam logic [255:0] TBL = 256'h11B2_10A1;

    logic clock = 1'b0, reset_n = 1'b0, hpd = 1'b0, over = 1'b0;
    logic link_run, scrambler_enable, tmds_bit_clock_ratio, hdmi2_sink, link_error;

    hdmi_link_manager_if i2c();

    hdmi_link_manager #(
        .CLOCK_FREQUENCY(CF), .DEBOUNCE_MS(DEB), .BACKOFF_MS(BO), .RETRY_LIMIT(RL),
        .REDRIVER_ADDRESS(7'h5E), .REDRIVER_COUNT(RC), .REDRIVER_TABLE(TBL), .POLL_MS(PM)
    ) dut (
        .clock(clock), .reset_n(reset_n), .hpd(hpd), .over_340mhz(over), .i2c(i2c.master),
        .link_run(link_run), .scrambler_enable(scrambler_enable),
        .tmds_bit_clock_ratio(tmds_bit_clock_ratio), .hdmi2_sink(hdmi2_sink), .link_error(link_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] a;
        logic       rw;
        logic [7:0] r;
        logic [7:0] d;
        int         kind;   // 0 redriver, 1 probe, 2 tmds write, 3 poll read
    } txn_t;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    txn_t   plan[$];
    bit     m_active, m_ready, m_link, m_scr, m_ratio, m_h2, m_err;
    int     m_retry;
    longint cyc = 0, m_due = -1, m_poll_due = -1, rise_cyc = 0;
    longint rise_q[$], nack_q[$];

    function automatic txn_t mk(input logic [6:0] a, input logic rw, input logic [7:0] r,
                                input logic [7:0] d, input int k);
        txn_t t;
        t.a = a; t.rw = rw; t.r = r; t.d = d; t.kind = k;
        return t;
    endfunction

    task automatic m_clear();
        plan.delete();
        m_ready = 0; m_link = 0; m_scr = 0; m_ratio = 0; m_h2 = 0; m_err = 0;
        m_retry = 0; m_due = -1; m_poll_due = -1; m_active = 0;
    endtask

    task automatic m_sched_poll();
`ifdef HDMI_LINK_SCDC_POLL_EN
        if (m_h2) m_poll_due = cyc + PM * DIV;
`endif
    endtask

    task automatic m_complete();
        txn_t t;
        logic [255:0] tb;
        t = plan.pop_front();
        tb = TBL;
        if (i2c.nack) begin
            nack_q.push_back(cyc);
            if (t.kind == 1 && !over) begin
                plan.delete(); m_link = 1;
            end else if (t.kind == 3) begin
                m_link = 0; plan.push_back(mk(7'h54, 0, 8'h20, {6'b0, over, over}, 2));
            end else begin
                plan.delete();
                if (m_retry == RL) m_err = 1;
                else begin m_retry++; m_due = cyc + BO * DIV; end
            end
        end else begin
            case (t.kind)
                1: begin m_h2 = 1; plan.push_back(mk(7'h54, 0, 8'h20, {6'b0, over, over}, 2)); end
                2: begin m_scr = over; m_ratio = over; m_link = 1; m_sched_poll(); end
                3: begin
                    if (i2c.data_read[1:0] != {m_ratio, m_scr}) begin
                        m_link = 0; plan.push_back(mk(7'h54, 0, 8'h20, {6'b0, over, over}, 2));
                    end else m_sched_poll();
                end
                default: ;
            endcase
        end
        if (plan.size() == 0) m_ready = 0;
        if (tb == 0) m_ready = 0;  // never true; keeps tb referenced for the start routine below
    endtask

    task automatic m_start();
        logic [255:0] tb;
        tb = TBL;
        plan.delete();
        for (int i = 0; i < RC; i++)
            plan.push_back(mk(7'h5E, 0, tb[16*i+8 +: 8], tb[16*i +: 8], 0));
        plan.push_back(mk(7'h54, 0, 8'h02, 8'h01, 1));
        m_ready = 1;
    endtask

    always @(posedge clock) begin
        cyc++;
        if (!reset_n || !hpd) m_clear();
        else if (!m_active) begin m_active = 1; rise_cyc = cyc; m_due = cyc + DEB * DIV; end
        else if (m_due == cyc) begin m_due = -1; m_start(); end
        else if (m_poll_due == cyc) begin
            m_poll_due = -1; plan.push_back(mk(7'h54, 1, 8'h20, 8'h00, 3)); m_ready = 1;
        end
        else if (m_ready && i2c.valid) m_complete();
    end

    // ---------------- per-cycle compare ----------------
    bit prev_ready = 0;
    always @(negedge clock) begin
        check("ready", i2c.ready, m_ready);
        check("link_run", link_run, m_link);
        check("scrambler", scrambler_enable, m_scr);
        check("ratio", tmds_bit_clock_ratio, m_ratio);
        check("hdmi2_sink", hdmi2_sink, m_h2);
        check("link_error", link_error, m_err);
        if (m_ready && plan.size() > 0) begin
            check("req_addr", i2c.address, plan[0].a);
            check("req_rw", i2c.rw, plan[0].rw);
            check("req_reg", i2c.register, plan[0].r);
            if (!plan[0].rw) check("req_data", i2c.data_write, plan[0].d);
        end
        if (i2c.ready === 1'b1 && !prev_ready) rise_q.push_back(cyc);
        prev_ready = (i2c.ready === 1'b1);
    end

    // ---------------- I2C responder ----------------
    int   mode = 0, fixed_lat = 0, lat_left = 0;
    bit   poll_zero = 0;
    txn_t log_q[$];

    initial begin
        i2c.valid = 0; i2c.nack = 0; i2c.data_read = 0;
        forever begin
            @(negedge clock);
            i2c.valid = 0; i2c.nack = 0;
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    i2c.valid = 1;
                    case (mode)
                        1: i2c.nack = (i2c.address == 7'h54 && i2c.register == 8'h02);
                        2: i2c.nack = (i2c.address == 7'h5E && i2c.register == 8'h11);
                        3: i2c.nack = ($urandom_range(0, 5) == 0);
                        default: i2c.nack = 0;
                    endcase
                    if (poll_zero) i2c.data_read = 8'h00;
                    else if (mode == 3 && $urandom_range(0, 2) == 0) i2c.data_read = 8'($urandom);
                    else i2c.data_read = {6'b0, over, over};
                    if (i2c.ready === 1'b1)
                        log_q.push_back(mk(i2c.address, i2c.rw, i2c.register, i2c.data_write, 0));
                end
            end else if (i2c.ready === 1'b1) begin
                lat_left = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
            end
        end
    end

    // ---------------- scenarios ----------------
    function automatic logic sel(input int w);
        case (w)
            0: return link_run;
            1: return link_error;
            2: return i2c.ready;
            default: return !link_run;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int w, input int bound);
        int k = 0;
        while (sel(w) !== 1'b1 && k < bound) begin @(negedge clock); k++; end
        check(nm, sel(w), 1'b1);
    endtask

    task automatic drop_hpd(input int n);
        hpd = 0;
        repeat (n) @(negedge clock);
    endtask

    function automatic int count_reg(input logic [7:0] r, input logic rw);
        int c = 0;
        foreach (log_q[i]) if (log_q[i].r == r && log_q[i].rw == rw) c++;
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clock);
        check("rst_outputs", {i2c.ready, link_run, scrambler_enable, tmds_bit_clock_ratio,
                              hdmi2_sink, link_error}, 6'b0);
        reset_n = 1;
        repeat (2) @(negedge clock);

        // all ACK, >340 MHz
        over = 1; mode = 0; log_q.delete(); rise_q.delete(); hpd = 1;
        wait_for("t1_link", 0, 300);
        check("t1_scr", scrambler_enable, 1);
        check("t1_ratio", tmds_bit_clock_ratio, 1);
        check("t1_h2", hdmi2_sink, 1);
        check("t1_nrise", rise_q.size(), 1);
        if (rise_q.size() > 0) check("t1_ready_delay", 32'(rise_q[0] - rise_cyc), 20);
        check("t1_nlog", log_q.size(), 4);
        if (log_q.size() >= 4) begin
            check("t1_txn0", {log_q[0].a, log_q[0].rw, log_q[0].r, log_q[0].d}, {7'h5E, 1'b0, 8'h10, 8'hA1});
            check("t1_txn1", {log_q[1].a, log_q[1].rw, log_q[1].r, log_q[1].d}, {7'h5E, 1'b0, 8'h11, 8'hB2});
            check("t1_txn2", {log_q[2].a, log_q[2].rw, log_q[2].r, log_q[2].d}, {7'h54, 1'b0, 8'h02, 8'h01});
            check("t1_txn3", {log_q[3].a, log_q[3].rw, log_q[3].r, log_q[3].d}, {7'h54, 1'b0, 8'h20, 8'h03});
        end
        drop_hpd(3);

        // HDMI 1.4 sink: probe NACK below 340 MHz
        over = 0; mode = 1; log_q.delete(); hpd = 1;
        wait_for("t2_link", 0, 300);
        check("t2_scr", scrambler_enable, 0);
        check("t2_h2", hdmi2_sink, 0);
        check("t2_no_tmds", count_reg(8'h20, 0), 0);
        check("t2_nlog", log_q.size(), 3);
        drop_hpd(3);

        // redriver entry 1 always NACKs: one backoff then FAIL
        over = 1; mode = 2; log_q.delete(); rise_q.delete(); nack_q.delete(); hpd = 1;
        wait_for("t3_error", 1, 400);
        check("t3_link", link_run, 0);
        check("t3_entry0_writes", count_reg(8'h10, 0), 2);
        check("t3_nnack", nack_q.size(), 2);
        check("t3_nrise", rise_q.size(), 2);
        if (rise_q.size() >= 2 && nack_q.size() >= 1)
            check("t3_backoff", 32'(rise_q[1] - nack_q[0]), 10);
        drop_hpd(3);
        check("t3_error_cleared", link_error, 0);

        // hpd drop mid-transfer; the late completion must be ignored
        mode = 0; fixed_lat = 4; hpd = 1;
        wait_for("t4_ready", 2, 100);
        @(negedge clock);
        hpd = 0;
        @(negedge clock);
        check("t4_ready_drop", i2c.ready, 0);
        repeat (6) @(negedge clock);
        check("t4_idle", {link_run, hdmi2_sink}, 2'b00);
        fixed_lat = 0;

        // one-cycle hpd glitch during debounce restarts the 20-cycle wait
        hpd = 1;
        repeat (5) @(negedge clock);
        hpd = 0;
        @(negedge clock);
        rise_q.delete(); hpd = 1;
        wait_for("t5_ready", 2, 100);
        if (rise_q.size() > 0) check("t5_ready_delay", 32'(rise_q[0] - rise_cyc), 20);
        wait_for("t5_link", 0, 200);

`ifdef HDMI_LINK_SCDC_POLL_EN
        // poll returns 0x00: link drops, TMDS config rewritten, link returns
        log_q.delete(); poll_zero = 1;
        wait_for("t6_link_drop", 3, 200);
        poll_zero = 0;
        wait_for("t6_link_back", 0, 100);
        check("t6_nlog", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("t6_read", {log_q[0].a, log_q[0].rw, log_q[0].r}, {7'h54, 1'b1, 8'h20});
            check("t6_rewrite", {log_q[1].a, log_q[1].rw, log_q[1].r, log_q[1].d}, {7'h54, 1'b0, 8'h20, 8'h03});
        end
`endif
        drop_hpd(3);

        // random sessions: random rate, random NACKs, random latencies and hold times
        mode = 3;
        repeat (12) begin
            over = 1'($urandom);
            hpd = 1;
            repeat ($urandom_range(40, 300)) @(negedge clock);
            drop_hpd($urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
